// File: rtl/cache_pkg.sv
// Shared cache constants and types used by the way-select / read-out path.
package cache_pkg;

  localparam int CACHE_WAYS      = 16;
  localparam int CACHE_LINE_BITS = 512;
  localparam int CACHE_BEAT_BITS = 64;
  localparam int CACHE_NBEATS    = CACHE_LINE_BITS / CACHE_BEAT_BITS;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hit_encoder.sv
// Lowest-index priority encode of a tag-hit vector, with any-hit and
// more-than-one-hit flags.
module hit_encoder
  import cache_pkg::*;
#(
  parameter int WAYS = CACHE_WAYS
) (
  input  logic [WAYS-1:0]           hit,
  output logic [idx_bits(WAYS)-1:0] index,
  output logic                      any,
  output logic                      multi
);

  localparam int IDX_W = idx_bits(WAYS);

  // Scanning upward, the first set bit wins; any later set bit marks multi.
  always_comb begin
    index = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          index = IDX_W'(i);
        end
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/way_read_mux.sv
// Selects the hitting way's line, captures it, and streams it out as
// critical-beat-first wrapping bursts over a valid/ready channel.
module way_read_mux
  import cache_pkg::*;
#(
  parameter int WAYS      = CACHE_WAYS,
  parameter int LINE_BITS = CACHE_LINE_BITS,
  parameter int BEAT_BITS = CACHE_BEAT_BITS
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       req_valid,
  output logic                                       req_ready,
  input  logic [WAYS-1:0]                            req_hit,
  input  logic [idx_bits(LINE_BITS/BEAT_BITS)-1:0]   req_beat,
  input  logic [WAYS*LINE_BITS-1:0]                  way_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [BEAT_BITS-1:0]                       out_data,
  output logic                                       out_last,
  output logic                                       miss,
  output logic                                       multi_hit
);

  localparam int NBEATS = LINE_BITS / BEAT_BITS;
  localparam int BEAT_W = idx_bits(NBEATS);
  localparam int WAY_W  = idx_bits(WAYS);

  rd_state_e              state_reg;
  logic [LINE_BITS-1:0]   line_reg;
  logic [BEAT_W-1:0]      beat_reg;
  logic [BEAT_W-1:0]      last_beat_reg;
  logic [BEAT_W-1:0]      beat_next;

  logic [WAY_W-1:0]       hit_index;
  logic                   hit_any;
  logic                   hit_multi;

  logic [LINE_BITS-1:0]   way_line   [WAYS];
  logic [LINE_BITS-1:0]   sel_line;
  logic [BEAT_BITS-1:0]   sel_beats  [NBEATS];
  logic [BEAT_BITS-1:0]   held_beats [NBEATS];

  hit_encoder #(
    .WAYS (WAYS)
  ) u_hit_encoder (
    .hit   (req_hit),
    .index (hit_index),
    .any   (hit_any),
    .multi (hit_multi)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way_split
      assign way_line[gi] = way_data[gi*LINE_BITS +: LINE_BITS];
    end
    for (gi = 0; gi < NBEATS; gi++) begin : g_beat_split
      assign sel_beats[gi]  = sel_line[gi*BEAT_BITS +: BEAT_BITS];
      assign held_beats[gi] = line_reg[gi*BEAT_BITS +: BEAT_BITS];
    end
  endgenerate

  assign sel_line  = way_line[hit_index];
  assign beat_next = beat_reg + 1'b1;
  assign req_ready = (state_reg == IDLE);

  // NBEATS is a power of two, so the beat counter wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      line_reg      <= '0;
      beat_reg      <= '0;
      last_beat_reg <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      miss          <= 1'b0;
      multi_hit     <= 1'b0;
    end else begin
      miss      <= 1'b0;
      multi_hit <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (!hit_any) begin
              miss <= 1'b1;
            end else begin
              multi_hit     <= hit_multi;
              line_reg      <= sel_line;
              beat_reg      <= req_beat;
              last_beat_reg <= req_beat - 1'b1;
              out_data      <= sel_beats[req_beat];
              out_valid     <= 1'b1;
              out_last      <= 1'b0;
              state_reg     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              beat_reg <= beat_next;
              out_data <= held_beats[beat_next];
              out_last <= (beat_next == last_beat_reg);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_way_read_mux.sv
// Directed, table-driven bench for way_read_mux (16 ways, 8 beats of 64 bits).
module tb_way_read_mux;

  localparam int WAYS      = 16;
  localparam int LINE_BITS = 512;
  localparam int BEAT_BITS = 64;
  localparam int NBEATS    = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      req_valid;
  logic                      req_ready;
  logic [WAYS-1:0]           req_hit;
  logic [2:0]                req_beat;
  logic [WAYS*LINE_BITS-1:0] way_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [BEAT_BITS-1:0]      out_data;
  logic                      out_last;
  logic                      miss;
  logic                      multi_hit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  way_read_mux #(
    .WAYS      (WAYS),
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_hit   (req_hit),
    .req_beat  (req_beat),
    .way_data  (way_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .miss      (miss),
    .multi_hit (multi_hit)
  );

  typedef struct {
    logic [15:0] hit;
    logic [2:0]  beat;
    logic [3:0]  rdy;    // out_ready pattern, bit n used on cycle n mod 4
    int          way;
    logic        exp_miss;
    logic        exp_multi;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_val(input int seed, input int w, input int k);
    return {8'(seed), 8'(w), 8'(k), 8'hA5, 32'(w * 1000 + k * 37 + seed * 7 + 1)};
  endfunction

  task automatic fill_ways(input int seed);
    for (int w = 0; w < WAYS; w++)
      for (int k = 0; k < NBEATS; k++)
        way_data[w*LINE_BITS + k*BEAT_BITS +: BEAT_BITS] = beat_val(seed, w, k);
  endtask

  // Entered at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic run_vec(input vec_t v, input int id);
    int         n;
    int         cyc;
    logic [2:0] k;
    logic       hs;
    chk("req_ready_before_req", req_ready, 1);
    fill_ways(0);
    req_valid = 1'b1;
    req_hit   = v.hit;
    req_beat  = v.beat;
    out_ready = v.rdy[0];
    @(posedge clk); #1;
    // Change everything after accept: the captured line must not follow.
    req_valid = 1'b0;
    req_hit   = 16'hFFFF;
    req_beat  = ~v.beat;
    fill_ways(1);
    chk("miss_pulse", miss, v.exp_miss);
    chk("multi_hit_pulse", multi_hit, v.exp_multi);
    if (v.exp_miss) begin
      chk("miss_no_valid", out_valid, 0);
      chk("miss_req_ready", req_ready, 1);
      @(posedge clk); #1;
      chk("miss_pulse_end", miss, 0);
      chk("miss_no_valid_2", out_valid, 0);
      chk("miss_req_ready_2", req_ready, 1);
      $display("txn %0d: hit=%h -> miss, no beats", id, v.hit);
      return;
    end
    n   = 0;
    cyc = 0;
    while (n < NBEATS && cyc < 64) begin
      out_ready = v.rdy[cyc[1:0]];
      k = v.beat + 3'(n);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, beat_val(0, v.way, int'(k)));
      chk("out_last", out_last, (n == NBEATS - 1));
      chk("req_ready_busy", req_ready, 0);
      if (cyc == 1) begin
        chk("miss_one_cycle", miss, 0);
        chk("multi_one_cycle", multi_hit, 0);
      end
      hs = out_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) n++;
    end
    if (n < NBEATS) begin
      n_cmp++;
      n_bad++;
      $display("FAIL burst_timeout: got %0d beats expected %0d", n, NBEATS);
    end
    chk("valid_drop_after_last", out_valid, 0);
    chk("last_drop_after_last", out_last, 0);
    chk("req_ready_after_last", req_ready, 1);
    $display("txn %0d: hit=%h beat=%0d way=%0d multi=%0b beats=%0d cycles=%0d",
             id, v.hit, v.beat, v.way, v.exp_multi, n, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0020, 3'd0, 4'b1111, 5,  1'b0, 1'b0};
    vecs[1] = '{16'h0001, 3'd5, 4'b1111, 0,  1'b0, 1'b0};
    vecs[2] = '{16'h0000, 3'd3, 4'b1111, 0,  1'b1, 1'b0};
    vecs[3] = '{16'h0090, 3'd2, 4'b1111, 4,  1'b0, 1'b1};
    vecs[4] = '{16'h8000, 3'd7, 4'b1001, 15, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 3'd1, 4'b1111, 0,  1'b0, 1'b1};
    vecs[6] = '{16'h0006, 3'd4, 4'b1001, 1,  1'b0, 1'b1};
    vecs[7] = '{16'h4000, 3'd0, 4'b0101, 14, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_hit   = '0;
    req_beat  = '0;
    out_ready = 1'b0;
    fill_ways(0);

    @(posedge clk); #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_miss", miss, 0);
    chk("rst_multi_hit", multi_hit, 0);
    chk("rst_req_ready", req_ready, 1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_release", req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset asserted between edges while beat 3 is on the bus.
    fill_ways(0);
    req_valid = 1'b1;
    req_hit   = 16'h0020;
    req_beat  = 3'd0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_beat3", out_data, beat_val(0, 5, 3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_out_last", out_last, 0);
    chk("async_rst_req_ready", req_ready, 1);
    $display("txn reset: rst_n pulsed during beat 3, outputs cleared");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_mid_reset", req_ready, 1);
    run_vec(vecs[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/way_read_mux.md
WAY_READ_MUX -- requirements
Module: way_read_mux

Interface
REQ-001 SHALL have parameter WAYS, default 16, number of cache ways (legal 2..16).
REQ-002 SHALL have parameter LINE_BITS, default 512, cache line width in bits.
REQ-003 SHALL have parameter BEAT_BITS, default 64, output beat width; LINE_BITS is an integer multiple of BEAT_BITS; NBEATS = LINE_BITS/BEAT_BITS, a power of two >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  read request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_hit  input  WAYS  per-way tag-match vector.
REQ-009 SHALL have port req_beat  input  clog2(NBEATS)  critical beat to send first.
REQ-010 SHALL have port way_data  input  WAYS*LINE_BITS  all way lines, way i at bits [i*LINE_BITS +: LINE_BITS].
REQ-011 SHALL have port out_valid  output  1  beat present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-013 SHALL have port out_data  output  BEAT_BITS  current beat.
REQ-014 SHALL have port out_last  output  1  current beat is final beat of burst.
REQ-015 SHALL have port miss  output  1  one-cycle pulse: accepted request had no hit.
REQ-016 SHALL have port multi_hit  output  1  one-cycle pulse: accepted request had >1 hit bit.

Function
REQ-017 SHALL implement FSM states IDLE and STREAM; req_ready = 1 only in IDLE.
REQ-018 Request accepted when req_valid && req_ready at a rising edge.
REQ-019 On accept with req_hit == 0: SHALL pulse miss next cycle, stay IDLE, produce no beats.
REQ-020 On accept with req_hit != 0: SHALL register the line of the lowest-index set way, go to STREAM; way_data ignored after accept edge.
REQ-021 On accept with >1 hit bit: SHALL pulse multi_hit next cycle and still stream the lowest-index way.
REQ-022 First beat SHALL appear with out_valid = 1 in the cycle after accept (latency 1).
REQ-023 Beat order SHALL be critical-word-first with wrap: req_beat, req_beat+1, ... modulo NBEATS; beat k = line bits [k*BEAT_BITS +: BEAT_BITS].
REQ-024 Beat advances only on out_valid && out_ready; out_data, out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 out_last SHALL be 1 exactly on the NBEATS-th beat of the burst (beat index req_beat-1 mod NBEATS).
REQ-026 Handshake on last beat SHALL return FSM to IDLE, out_valid = 0 next cycle; one idle cycle between consecutive bursts.
REQ-027 out_valid SHALL not depend combinationally on out_ready.
REQ-028 req_beat = 0 SHALL stream in natural order 0..NBEATS-1 with no wrap.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out_valid/out_last/miss/multi_hit = 0, out_data = 0, beat counter = 0, independent of clk.
REQ-030 Reset asserted mid-burst SHALL discard remaining beats; first request after release starts a fresh burst.
REQ-031 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 State enum (IDLE, STREAM) SHALL live in shared package cache_pkg alongside existing cache constants.
REQ-033 Lowest-index one-hot-to-index encode plus population>1 detect SHALL be a sub-module hit_encoder (parameter WAYS; outputs index, any, multi).
REQ-034 Line register, beat counter, FSM SHALL live in way_read_mux.

Verification
REQ-035 WAYS=16, NBEATS=8, req_hit=16'h0020, req_beat=0, out_ready=1 -> beats 0..7 of way 5 on 8 consecutive cycles, out_last on 8th, req_ready back 1 cycle later.
REQ-036 req_hit=16'h0001, req_beat=5 -> beat order 5,6,7,0,1,2,3,4; out_last on beat 4.
REQ-037 req_hit=16'h0000 -> miss pulses 1 cycle, out_valid stays 0, req_ready stays 1.
REQ-038 req_hit=16'h0090 -> multi_hit pulses 1 cycle, way 4 data streamed.
REQ-039 out_ready toggled 1,0,0,1 each beat -> out_data/out_last stable across stalls, no beat dropped or repeated.
REQ-040 rst_n pulsed low during beat 3 -> outputs 0 asynchronously; next request streams a complete 8-beat burst.
